// File: rtl/output_buffer_3x3_pkg.sv
// Shared types, geometry constants and address helper for the padded 3x3 output buffer.
// The layer geometry is fixed here so that every file in the slice agrees on the widths.
package output_buffer_3x3_pkg;

    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned OUT_CHANNELS = 3;
    localparam int unsigned IN_WIDTH     = 5;
    localparam int unsigned IN_HEIGHT    = 5;

    localparam int unsigned PAD_W = IN_WIDTH + 2;
    localparam int unsigned PAD_H = IN_HEIGHT + 2;
    localparam int unsigned N_PIX = IN_WIDTH * IN_HEIGHT;
    localparam int unsigned DEPTH = PAD_W * PAD_H * OUT_CHANNELS;

    localparam int unsigned WR_ADDR_W = $clog2(DEPTH);
    localparam int unsigned RD_ADDR_W = $clog2(N_PIX);
    localparam int unsigned CH_W      = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int unsigned COL_W     = $clog2(PAD_W);
    localparam int unsigned ROW_W     = $clog2(PAD_H);

    typedef enum logic [1:0] {
        ST_PAD   = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  en;
        logic                  is_padding;
        logic [WR_ADDR_W-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } buf_wr_t;

    // Padded-raster coordinate to flat buffer address, channel fastest.
    function automatic logic [WR_ADDR_W-1:0] buf_addr(input logic [ROW_W-1:0] row_p,
                                                      input logic [COL_W-1:0] col_p,
                                                      input logic [CH_W-1:0]  ch);
        return WR_ADDR_W'((32'(row_p) * 32'(PAD_W) + 32'(col_p)) * 32'(OUT_CHANNELS) + 32'(ch));
    endfunction

endpackage

// File: rtl/output_buffer_3x3_ctrl_if.sv
// Stream-in, buffer-control and window-out signals of the output buffer sequencer.
// master: the sequencer; slave: the surrounding conv engine, buffer and next layer.
interface output_buffer_3x3_ctrl_if;
    import output_buffer_3x3_pkg::*;

    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] buf_wr_data;
    logic [WR_ADDR_W-1:0]  buf_wr_addr;
    logic                  buf_is_padding;
    logic                  buf_wr_en;
    logic [RD_ADDR_W-1:0]  buf_rd_addr;
    logic                  buf_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic                  frame_done;

    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, buf_wr_data, buf_wr_addr, buf_is_padding, buf_wr_en,
               buf_rd_addr, buf_rd_en, m_valid, frame_done
    );

    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, buf_wr_data, buf_wr_addr, buf_is_padding, buf_wr_en,
               buf_rd_addr, buf_rd_en, m_valid, frame_done
    );

endinterface

// File: rtl/output_buffer_3x3_raster_cnt.sv
// Nested ch -> col -> row raster counter; skip_col jumps from the end of a channel sweep
// straight to the last column so a caller can walk only the border of a padded frame.
module output_buffer_3x3_raster_cnt #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned N_COL = 7,
    parameter int unsigned N_ROW = 7,
    parameter int unsigned CH_W  = 2,
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             skip_col,
    output logic [CH_W-1:0]  ch,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             wrap
);

    logic ch_last;
    logic col_last;
    logic row_last;

    assign ch_last  = (ch  == CH_W'(N_CH - 1));
    assign col_last = (col == COL_W'(N_COL - 1));
    assign row_last = (row == ROW_W'(N_ROW - 1));
    assign wrap     = en && ch_last && col_last && row_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (ch_last) begin
                ch <= '0;
                if (skip_col) begin
                    col <= COL_W'(N_COL - 1);
                end else if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end else begin
                ch <= ch + CH_W'(1);
            end
        end
    end

endmodule

// File: rtl/output_buffer_3x3_ctrl.sv
// Sequencer for the padded 3x3 output buffer: border clear, frame fill, window drain.
// OUTPUT_BUFFER_3X3_CTRL_PAD_EN enables the one-shot border-zeroing PAD pass after reset.
module output_buffer_3x3_ctrl
    import output_buffer_3x3_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    output_buffer_3x3_ctrl_if.master bus
);

`ifdef OUTPUT_BUFFER_3X3_CTRL_PAD_EN
    localparam state_t RST_STATE = ST_PAD;
`else
    localparam state_t RST_STATE = ST_FILL;
`endif

    state_t               state;
    state_t               state_nxt;
    buf_wr_t              wr_q;
    buf_wr_t              wr_d;
    logic                 s_ready_q;
    logic                 s_ready_d;
    logic                 m_valid_q;
    logic                 m_valid_d;
    logic                 frame_done_q;
    logic                 frame_done_d;
    logic [RD_ADDR_W-1:0] rd_addr_q;
    logic [RD_ADDR_W-1:0] rd_addr_d;
    logic                 rd_done_q;
    logic                 rd_done_d;
    logic                 fire;
    logic                 rd_issue;
    logic                 last_accept;

    logic [CH_W-1:0]      fill_ch;
    logic [COL_W-1:0]     fill_col;
    logic [ROW_W-1:0]     fill_row;
    logic                 fill_wrap;

    assign fire        = (state == ST_FILL) && s_ready_q && bus.s_valid;
    // Read issue is combinational on m_ready so a stalled window is never overwritten.
    assign rd_issue    = !rst && (state == ST_DRAIN) && !rd_done_q && (!m_valid_q || bus.m_ready);
    assign last_accept = (state == ST_DRAIN) && rd_done_q && m_valid_q && bus.m_ready;

    output_buffer_3x3_raster_cnt #(
        .N_CH (OUT_CHANNELS), .N_COL(IN_WIDTH), .N_ROW(IN_HEIGHT),
        .CH_W (CH_W),         .COL_W(COL_W),    .ROW_W(ROW_W)
    ) u_fill_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (fire),
        .skip_col(1'b0),
        .ch      (fill_ch),
        .col     (fill_col),
        .row     (fill_row),
        .wrap    (fill_wrap)
    );

`ifdef OUTPUT_BUFFER_3X3_CTRL_PAD_EN
    logic [CH_W-1:0]  pad_ch;
    logic [COL_W-1:0] pad_col;
    logic [ROW_W-1:0] pad_row;
    logic             pad_wrap;
    logic             pad_skip;

    // Interior rows only touch column 0 and the last column.
    assign pad_skip = (pad_row != '0) && (pad_row != ROW_W'(PAD_H - 1)) && (pad_col == '0);

    output_buffer_3x3_raster_cnt #(
        .N_CH (OUT_CHANNELS), .N_COL(PAD_W), .N_ROW(PAD_H),
        .CH_W (CH_W),         .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_pad_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_PAD),
        .skip_col(pad_skip),
        .ch      (pad_ch),
        .col     (pad_col),
        .row     (pad_row),
        .wrap    (pad_wrap)
    );
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST_STATE;
            wr_q         <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_done_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_q         <= wr_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            frame_done_q <= frame_done_d;
            rd_addr_q    <= rd_addr_d;
            rd_done_q    <= rd_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef OUTPUT_BUFFER_3X3_CTRL_PAD_EN
            ST_PAD:   if (pad_wrap) state_nxt = ST_FILL;
`else
            ST_PAD:   state_nxt = ST_FILL;
`endif
            ST_FILL:  if (fill_wrap) state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_accept) state_nxt = ST_FILL;
            default:  state_nxt = ST_FILL;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        wr_d         = '0;
        s_ready_d    = (state_nxt == ST_FILL);
        m_valid_d    = m_valid_q;
        frame_done_d = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_done_d    = rd_done_q;
        case (state)
`ifdef OUTPUT_BUFFER_3X3_CTRL_PAD_EN
            ST_PAD: begin
                wr_d.en         = 1'b1;
                wr_d.is_padding = 1'b1;
                wr_d.addr       = buf_addr(pad_row, pad_col, pad_ch);
            end
`endif
            ST_FILL: begin
                if (fire) begin
                    wr_d.en   = 1'b1;
                    wr_d.addr = buf_addr(fill_row + ROW_W'(1), fill_col + COL_W'(1), fill_ch);
                    wr_d.data = bus.s_data;
                end
            end
            ST_DRAIN: begin
                if (rd_issue) begin
                    m_valid_d = 1'b1;
                    if (rd_addr_q == RD_ADDR_W'(N_PIX - 1)) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + RD_ADDR_W'(1);
                    end
                end else if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                end
                if (last_accept) begin
                    frame_done_d = 1'b1;
                    rd_addr_d    = '0;
                    rd_done_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.buf_wr_en      = wr_q.en;
    assign bus.buf_wr_addr    = wr_q.addr;
    assign bus.buf_wr_data    = wr_q.data;
    assign bus.buf_is_padding = wr_q.is_padding;
    assign bus.buf_rd_en      = rd_issue;
    assign bus.buf_rd_addr    = rd_addr_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.frame_done     = frame_done_q;

endmodule

// File: tb/tb_output_buffer_3x3_ctrl.sv
// Directed bench for output_buffer_3x3_ctrl: border clear, fill, drain, backpressure, reset abort.
module tb_output_buffer_3x3_ctrl;
    import output_buffer_3x3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   pad_q[$];
    logic [RD_ADDR_W-1:0] win = '0;

`ifdef OUTPUT_BUFFER_3X3_CTRL_PAD_EN
    localparam int EXP_PAD = 72;
`else
    localparam int EXP_PAD = 0;
`endif

    output_buffer_3x3_ctrl_if bus ();

    output_buffer_3x3_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Buffer read-port model: holds the centre of the last issued read.
    always @(posedge clk) if (bus.buf_rd_en === 1'b1) win <= bus.buf_rd_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic mr);
        @(posedge clk); #1;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.m_ready = mr;
        @(negedge clk);
    endtask

    function automatic bit is_interior(input int a);
        int pix = a / 3;
        int r   = pix / 7;
        int c   = pix % 7;
        return (r >= 1) && (r <= 5) && (c >= 1) && (c <= 5);
    endfunction

    function automatic int exp_fill_addr(input int k);
        int ch = k % 3;
        int c  = (k / 3) % 5;
        int r  = k / 15;
        return ((r + 1) * 7 + c + 1) * 3 + ch;
    endfunction

    task automatic test_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.s_ready, bus.m_valid, bus.buf_wr_en, bus.buf_rd_en, bus.buf_is_padding, bus.frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {bus.s_ready, bus.m_valid, bus.buf_wr_en, bus.buf_rd_en, bus.buf_is_padding, bus.frame_done});
        end
        checks++;
        if ({bus.buf_wr_data, bus.buf_wr_addr, bus.buf_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_buses: wr_data=%0h wr_addr=%0h rd_addr=%0h required all 0",
                     bus.buf_wr_data, bus.buf_wr_addr, bus.buf_rd_addr);
        end
    endtask

    // Releases reset and watches the border pass until s_ready rises.
    task automatic test_pad(input string tag);
        int n = 0, wr = 0, seq_err = 0, int_err = 0, mv_err = 0;
        bit rdy = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        while (!rdy && n < 300) begin
            if (bus.buf_wr_en === 1'b1) begin
                if (wr >= pad_q.size() || bus.buf_wr_addr !== WR_ADDR_W'(pad_q[wr]) ||
                    bus.buf_is_padding !== 1'b1 || bus.buf_wr_data !== 8'h00) seq_err++;
                if (is_interior(int'(bus.buf_wr_addr))) int_err++;
                wr++;
            end
            if (bus.m_valid !== 1'b0 || bus.buf_rd_en !== 1'b0) mv_err++;
            if (bus.s_ready === 1'b1) rdy = 1;
            else begin
                n++;
                cyc(1'b0, 8'h00, 1'b1);
            end
        end
        checks++;
        if (!rdy) begin errors++; $display("FAIL %s_ready: s_ready never rose within %0d cycles", tag, n); end
        checks++;
        if (wr != EXP_PAD) begin errors++; $display("FAIL %s_count: got %0d writes required %0d", tag, wr, EXP_PAD); end
        checks++;
        if (seq_err != 0) begin errors++; $display("FAIL %s_sequence: %0d writes off the border sequence, required 0", tag, seq_err); end
        checks++;
        if (int_err != 0) begin errors++; $display("FAIL %s_interior: %0d interior writes required 0", tag, int_err); end
        checks++;
        if (mv_err != 0) begin errors++; $display("FAIL %s_no_window: %0d cycles with m_valid/rd_en, required 0", tag, mv_err); end
    endtask

    task automatic test_fill(input string tag, input bit gaps, input logic [7:0] xorv);
        int beats = 0, wr = 0, err = 0, n = 0;
        bit done = 0;
        while (!done && n < 400) begin
            cyc((beats < 75) && !(gaps && (n % 4 == 3)), 8'(beats) ^ xorv, 1'b1);
            n++;
            if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) beats++;
            if (bus.buf_wr_en === 1'b1) begin
                if (bus.buf_wr_addr !== WR_ADDR_W'(exp_fill_addr(wr)) ||
                    bus.buf_wr_data !== (8'(wr) ^ xorv) || bus.buf_is_padding !== 1'b0) err++;
                wr++;
                if (wr == 75) done = 1;
            end
            if (bus.m_valid !== 1'b0 || (!done && bus.buf_rd_en !== 1'b0)) err++;
        end
        checks++;
        if (beats != 75 || wr != 75) begin
            errors++;
            $display("FAIL %s_count: got beats=%0d writes=%0d required 75/75", tag, beats, wr);
        end
        checks++;
        if (err != 0) begin errors++; $display("FAIL %s_writes: %0d bad write cycles required 0", tag, err); end
        checks++;
        if (bus.s_ready !== 1'b0 || bus.buf_rd_en !== 1'b1 || bus.buf_rd_addr !== '0) begin
            errors++;
            $display("FAIL %s_to_drain: s_ready=%b rd_en=%b rd_addr=%0d required 0/1/0",
                     tag, bus.s_ready, bus.buf_rd_en, bus.buf_rd_addr);
        end
    endtask

    task automatic test_drain(input string tag, input bit toggle, input int stop_at);
        int issues = 0, accs = 0, fd = 0, fd_idx = -1, last_idx = -1;
        int order_err = 0, stall_err = 0, n = 0;
        bit done = 0, prev_stall = 0;
        while (!done && n < 300) begin
            if (bus.frame_done === 1'b1) begin fd++; fd_idx = n; done = 1; end
            if (prev_stall && bus.m_valid !== 1'b1) stall_err++;
            if (bus.buf_rd_en === 1'b1) begin
                if (int'(bus.buf_rd_addr) != issues) order_err++;
                issues++;
            end
            prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            if (prev_stall && bus.buf_rd_en !== 1'b0) stall_err++;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (int'(win) != accs) order_err++;
                accs++;
                last_idx = n;
            end
            if (stop_at > 0 && accs == stop_at) done = 1;
            if (!done) begin
                n++;
                cyc(1'b0, 8'h00, toggle ? (n % 3 == 0) : 1'b1);
            end
        end
        checks++;
        if (order_err != 0 || stall_err != 0) begin
            errors++;
            $display("FAIL %s_windows: order_err=%0d stall_err=%0d required 0/0", tag, order_err, stall_err);
        end
        if (stop_at > 0) begin
            checks++;
            if (accs != stop_at || fd != 0) begin
                errors++;
                $display("FAIL %s_partial: got accepts=%0d frame_done=%0d required %0d/0", tag, accs, fd, stop_at);
            end
        end else begin
            checks++;
            if (accs != 25 || issues != 25) begin
                errors++;
                $display("FAIL %s_count: got accepts=%0d issues=%0d required 25/25", tag, accs, issues);
            end
            checks++;
            if (fd != 1 || fd_idx != last_idx + 1) begin
                errors++;
                $display("FAIL %s_frame_done: got pulses=%0d at %0d required 1 at %0d", tag, fd, fd_idx, last_idx + 1);
            end
            if (!toggle) begin
                checks++;
                if (last_idx != 25) begin
                    errors++;
                    $display("FAIL %s_throughput: last accept in cycle %0d required 25", tag, last_idx);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got %b required 1", bus.s_ready); end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.frame_done !== 1'b0 || bus.buf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after_done: s_ready=%b frame_done=%b wr_en=%b required 1/0/0",
                     bus.s_ready, bus.frame_done, bus.buf_wr_en);
        end
        test_fill("fill2", 1'b1, 8'hA5);
        test_drain("drain2", 1'b1, 0);
    endtask

    task automatic test_reset_mid_drain();
        int bad = 0;
        test_fill("fill3", 1'b0, 8'h3C);
        test_drain("drain3", 1'b0, 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.buf_rd_en !== 1'b0 || bus.buf_rd_addr !== '0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: m_valid=%b rd_en=%b rd_addr=%0d s_ready=%b required 0/0/0/0",
                     bus.m_valid, bus.buf_rd_en, bus.buf_rd_addr, bus.s_ready);
        end
        test_pad("pad2");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            if (bus.m_valid !== 1'b0 || bus.buf_rd_en !== 1'b0 || bus.s_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_no_emit: %0d cycles emitting or not ready, required 0", bad); end
    endtask

    initial begin
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++)
                for (int ch = 0; ch < 3; ch++)
                    if (r == 0 || r == 6 || c == 0 || c == 6) pad_q.push_back((r * 7 + c) * 3 + ch);
        test_reset();
        test_pad("pad");
        test_fill("fill1", 1'b0, 8'h00);
        test_drain("drain1", 1'b0, 0);
        test_back_to_back();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_buffer_3x3_ctrl.md
# output_buffer_3x3_ctrl

Sequencer for the padded 3x3 output buffer of a convolution layer. Clears the zero border once, then repeatedly:
- accepts one frame of conv results from an upstream valid/ready stream and writes it into the buffer interior;
- sweeps the read port to emit one 3x3×OUT_CHANNELS window per input pixel to the next layer under a valid/ready handshake.

It sits between the conv engine output and the buffer, and drives all buffer write/read control pins.

## Interface
- DATA_WIDTH, 8, bits per sample
- OUT_CHANNELS, 3, channels per pixel
- IN_WIDTH, 5, unpadded frame width
- IN_HEIGHT, 5, unpadded frame height
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_data  in  DATA_WIDTH  input sample; order is channel fastest, then column, then row
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts input sample
- buf_wr_data  out  DATA_WIDTH  buffer write data
- buf_wr_addr  out  clog2(PAD_W·PAD_H·OUT_CHANNELS)  buffer write address
- buf_is_padding  out  1  force-zero write
- buf_wr_en  out  1  buffer write enable
- buf_rd_addr  out  clog2(IN_WIDTH·IN_HEIGHT)  window centre (unpadded raster index)
- buf_rd_en  out  1  buffer read enable; buffer output updates next edge, holds otherwise
- m_valid  out  1  buffer read data holds a valid window
- m_ready  in  1  downstream accepts window
- frame_done  out  1  one-cycle pulse when last window of a frame is accepted

## Operation
Derived constants:
- PAD_W = IN_WIDTH+2, PAD_H = IN_HEIGHT+2
- Buffer address = (row_p·PAD_W + col_p)·OUT_CHANNELS + ch

States:
- PAD: entered from reset. Walks padded raster (row_p, col_p, ch fastest) over border positions only (row_p∈{0,PAD_H−1} or col_p∈{0,PAD_W−1}). One write per cycle with buf_is_padding=1, buf_wr_data=0. Takes (PAD_W·PAD_H − IN_WIDTH·IN_HEIGHT)·OUT_CHANNELS cycles, then goes to FILL.
- FILL: s_ready=1. Each s_valid&&s_ready beat writes s_data to ((r+1)·PAD_W + c+1)·OUT_CHANNELS + ch, with buf_is_padding=0. Counters ch→c→r wrap in that order. The last beat (r=IN_HEIGHT−1, c=IN_WIDTH−1, ch=OUT_CHANNELS−1) moves the state to DRAIN.
- DRAIN: s_ready=0. A read is issued (buf_rd_en=1) when centres remain and (!m_valid || m_ready). buf_rd_addr increments after each issue, from 0 to IN_WIDTH·IN_HEIGHT−1.
  - m_valid rises the cycle after an issue.
  - m_valid clears on m_valid&&m_ready with no new issue in the same cycle.
  - Acceptance of the last window pulses frame_done and moves the state to FILL.
  - PAD is not revisited, because the border is never overwritten.
- FILL and DRAIN never overlap. A frame is fully drained before the next frame is accepted.

## Timing
- Reset values: s_ready=0, m_valid=0, buf_wr_en=0, buf_rd_en=0, buf_is_padding=0, buf_wr_data=0, buf_wr_addr=0, buf_rd_addr=0, frame_done=0. State=PAD (FILL without the macro).
- Write path is registered: a beat accepted at edge T appears on buf_wr_* during cycle T+1 and is committed at edge T+2.
- The first DRAIN read is issued no earlier than the cycle in which the last interior write is presented, so it sees complete data.
- Read latency 1: an issue at edge T gives a window valid after edge T+1.
- With m_ready held high, windows stream back to back: IN_WIDTH·IN_HEIGHT windows in IN_WIDTH·IN_HEIGHT+1 cycles.
- Backpressure: while m_valid&&!m_ready, buf_rd_en=0 and the window is held stable (the buffer holds its output when rd_en=0).
- Gaps in s_valid stall FILL counters. There is no timeout.
- rst at any cycle aborts the frame: outputs go to reset values and the next state is PAD (or FILL without the macro). Partial data is discarded.

## Configuration
- OUTPUT_BUFFER_3X3_CTRL_PAD_EN defined:
  - PAD state is present and runs once after every reset.
  - buf_is_padding is asserted only in PAD.
- Not defined:
  - PAD state is removed and reset enters FILL directly.
  - buf_is_padding is tied to 0.
  - Border zeroing is the integrator's responsibility, e.g. via memory init.

## Structure
- Shared package output_buffer_3x3_pkg:
  - state enum (PAD, FILL, DRAIN);
  - localparams PAD_W, PAD_H, DEPTH, address widths;
  - a function computing the buffer address from (row_p, col_p, ch).
- Sub-module output_buffer_3x3_raster_cnt: parameterised ch/col/row nested counter with enable, wrap and last flags. One instance is used for PAD (padded dims, border skip by its caller) and one for FILL (unpadded dims).

## Test plan
Defaults throughout.
- Reset then idle: exactly 72 writes, all buf_is_padding=1; first addr 0, last addr 146; no writes to interior addresses (e.g. 24 never written) → FILL, s_ready=1.
- Frame of 75 beats, s_data=beat index, s_valid always 1: beat 0 → addr 24, beat 74 → addr 122. State reaches DRAIN.
- Drain, m_ready=1: 25 windows in 26 cycles. buf_rd_addr runs 0..24. frame_done pulses once, on the 25th accept.
- Drain, m_ready toggling 1-in-3: every window is held unchanged while stalled. No window is lost or duplicated. buf_rd_en=0 while stalled.
- Second frame after frame_done: no PAD writes. s_ready=1 on the cycle after frame_done.
- rst asserted mid-DRAIN at window 10: m_valid=0 next cycle. PAD restarts at addr 0. The partial frame is not emitted.
